// File: rtl/tap_pkg.sv
// Shared TAP definitions: state codes, instruction opcodes, DR select and IR capture pattern.
package tap_pkg;

  typedef enum logic [3:0] {
    S_EX2_DR = 4'h0,
    S_EX1_DR = 4'h1,
    S_SH_DR  = 4'h2,
    S_PA_DR  = 4'h3,
    S_SEL_IR = 4'h4,
    S_UPD_DR = 4'h5,
    S_CAP_DR = 4'h6,
    S_SEL_DR = 4'h7,
    S_EX2_IR = 4'h8,
    S_EX1_IR = 4'h9,
    S_SH_IR  = 4'hA,
    S_PA_IR  = 4'hB,
    S_RTI    = 4'hC,
    S_UPD_IR = 4'hD,
    S_CAP_IR = 4'hE,
    S_TLR    = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  // Opcodes are truncated to the IR width at the point of use.
  localparam logic [31:0] OP_BYPASS      = 32'hFFFF_FFFF;
  localparam logic [31:0] OP_IDCODE      = 32'd1;
  localparam logic [31:0] OP_USER        = 32'd2;
  localparam logic [1:0]  CAP_IR_PATTERN = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine with decoded capture/shift/update strobes.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_next_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TLR:    state_d = tms_i ? S_TLR    : S_RTI;
      S_RTI:    state_d = tms_i ? S_SEL_DR : S_RTI;
      S_SEL_DR: state_d = tms_i ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: state_d = tms_i ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  state_d = tms_i ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: state_d = tms_i ? S_UPD_DR : S_PA_DR;
      S_PA_DR:  state_d = tms_i ? S_EX2_DR : S_PA_DR;
      S_EX2_DR: state_d = tms_i ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: state_d = tms_i ? S_SEL_DR : S_RTI;
      S_SEL_IR: state_d = tms_i ? S_TLR    : S_CAP_IR;
      S_CAP_IR: state_d = tms_i ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  state_d = tms_i ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: state_d = tms_i ? S_UPD_IR : S_PA_IR;
      S_PA_IR:  state_d = tms_i ? S_EX2_IR : S_PA_IR;
      S_EX2_IR: state_d = tms_i ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: state_d = tms_i ? S_SEL_DR : S_RTI;
      default:  state_d = S_TLR;
    endcase
  end

  assign state_o      = state_q;
  assign tlr_next_o   = (state_d == S_TLR);
  assign capture_dr_o = (state_q == S_CAP_DR);
  assign shift_dr_o   = (state_q == S_SH_DR);
  assign update_dr_o  = (state_q == S_UPD_DR);
  assign capture_ir_o = (state_q == S_CAP_IR);
  assign shift_ir_o   = (state_q == S_SH_IR);
  assign update_ir_o  = (state_q == S_UPD_IR);

endmodule

// File: rtl/tap_ctrl_param.sv
// Parameterised JTAG TAP controller: IR, BYPASS, IDCODE and a user data register.
module tap_ctrl_param
  import tap_pkg::*;
#(
  parameter int          IR_WIDTH = 4,
  parameter int          DR_WIDTH = 8,
  parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
  input  logic                GCLK_Pad,
  input  logic                TRST_Pad,
  input  logic                TMS_Pad,
  input  logic                TDI_Pad,
  output logic                TDO_Pad,
  output logic                state_obs0_Pad,
  output logic                state_obs1_Pad,
  output logic                state_obs2_Pad,
  output logic                state_obs3_Pad,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [DR_WIDTH-1:0] user_dr_q,
  output logic                user_upd
);

  tap_state_e state;
  logic tlr_next, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  tap_fsm u_fsm (
    .clk_i        (GCLK_Pad),
    .rst_ni       (TRST_Pad),
    .tms_i        (TMS_Pad),
    .state_o      (state),
    .tlr_next_o   (tlr_next),
    .capture_dr_o (cap_dr),
    .shift_dr_o   (sh_dr),
    .update_dr_o  (upd_dr),
    .capture_ir_o (cap_ir),
    .shift_ir_o   (sh_ir),
    .update_ir_o  (upd_ir)
  );

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_d;
  logic                byp_q, byp_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [DR_WIDTH-1:0] usr_sr_q, usr_sr_d, user_dr_d;
  logic                user_upd_d;
  dr_sel_e             dr_sel;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == IR_WIDTH'(OP_BYPASS))      dr_sel = DR_BYPASS;
    else if (ir_q == IR_WIDTH'(OP_IDCODE)) dr_sel = DR_IDCODE;
    else if (ir_q == IR_WIDTH'(OP_USER))   dr_sel = DR_USER;
  end

  always_comb begin
    ir_sr_d    = ir_sr_q;
    byp_d      = byp_q;
    id_sr_d    = id_sr_q;
    usr_sr_d   = usr_sr_q;
    ir_d       = ir_q;
    user_dr_d  = user_dr_q;
    user_upd_d = 1'b0;

    if (cap_ir)     ir_sr_d = IR_WIDTH'(CAP_IR_PATTERN);
    else if (sh_ir) ir_sr_d = {TDI_Pad, ir_sr_q[IR_WIDTH-1:1]};

    // Looking at the next state keeps ir_q at IDCODE for every cycle spent in TLR.
    if (tlr_next)    ir_d = IR_WIDTH'(OP_IDCODE);
    else if (upd_ir) ir_d = ir_sr_q;

    if (cap_dr) begin
      unique case (dr_sel)
        DR_IDCODE: id_sr_d  = IDCODE;
        DR_USER:   usr_sr_d = user_dr_q;
        default:   byp_d    = 1'b0;
      endcase
    end else if (sh_dr) begin
      unique case (dr_sel)
        DR_IDCODE: id_sr_d  = {TDI_Pad, id_sr_q[31:1]};
        DR_USER:   usr_sr_d = DR_WIDTH'({TDI_Pad, usr_sr_q} >> 1);
        default:   byp_d    = TDI_Pad;
      endcase
    end

    if (upd_dr && dr_sel == DR_USER) begin
      user_dr_d  = usr_sr_q;
      user_upd_d = 1'b1;
    end
  end

  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      ir_sr_q   <= '0;
      byp_q     <= 1'b0;
      id_sr_q   <= '0;
      usr_sr_q  <= '0;
      ir_q      <= IR_WIDTH'(OP_IDCODE);
      user_dr_q <= '0;
      user_upd  <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      byp_q     <= byp_d;
      id_sr_q   <= id_sr_d;
      usr_sr_q  <= usr_sr_d;
      ir_q      <= ir_d;
      user_dr_q <= user_dr_d;
      user_upd  <= user_upd_d;
    end
  end

  always_comb begin
    TDO_Pad = 1'b0;
    if (sh_ir) begin
      TDO_Pad = ir_sr_q[0];
    end else if (sh_dr) begin
      unique case (dr_sel)
        DR_IDCODE: TDO_Pad = id_sr_q[0];
        DR_USER:   TDO_Pad = usr_sr_q[0];
        default:   TDO_Pad = byp_q;
      endcase
    end
  end

  assign state_obs0_Pad = state[0];
  assign state_obs1_Pad = state[1];
  assign state_obs2_Pad = state[2];
  assign state_obs3_Pad = state[3];

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Bench for tap_ctrl_param: directed scenarios plus random TMS/TDI walks against a table-driven model.
module tb_tap_ctrl_param;

  localparam int          IR_W = 4;
  localparam int          DR_W = 8;
  localparam logic [31:0] ID   = 32'h1000_0001;

  logic GCLK_Pad = 1'b0;
  logic TRST_Pad = 1'b0;
  logic TMS_Pad  = 1'b1;
  logic TDI_Pad  = 1'b0;
  logic TDO_Pad;
  logic state_obs0_Pad, state_obs1_Pad, state_obs2_Pad, state_obs3_Pad;
  logic [IR_W-1:0] ir_q;
  logic [DR_W-1:0] user_dr_q;
  logic            user_upd;
  logic [3:0]      obs;

  tap_ctrl_param #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .IDCODE(ID)) dut (
    .GCLK_Pad       (GCLK_Pad),
    .TRST_Pad       (TRST_Pad),
    .TMS_Pad        (TMS_Pad),
    .TDI_Pad        (TDI_Pad),
    .TDO_Pad        (TDO_Pad),
    .state_obs0_Pad (state_obs0_Pad),
    .state_obs1_Pad (state_obs1_Pad),
    .state_obs2_Pad (state_obs2_Pad),
    .state_obs3_Pad (state_obs3_Pad),
    .ir_q           (ir_q),
    .user_dr_q      (user_dr_q),
    .user_upd       (user_upd)
  );

  assign obs = {state_obs3_Pad, state_obs2_Pad, state_obs1_Pad, state_obs0_Pad};

  always #5 GCLK_Pad = ~GCLK_Pad;

  int n_cmp = 0;
  int n_mis = 0;
  int upd_cnt = 0;

  always @(negedge GCLK_Pad) if (user_upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next-state tables indexed by the 4-bit state code, for TMS=0 and TMS=1.
  int nx0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nx1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  int              m_st;
  logic [IR_W-1:0] m_ir_sr, m_ir;
  logic            m_byp;
  logic [31:0]     m_id;
  logic [DR_W-1:0] m_usr, m_udr;
  logic            m_upd;

  function automatic int m_sel();
    if (m_ir == 1) return 1;
    if (m_ir == 2) return 2;
    return 0;
  endfunction

  function automatic logic m_tdo();
    if (m_st == 'hA) return m_ir_sr[0];
    if (m_st == 'h2) begin
      if (m_sel() == 1) return m_id[0];
      if (m_sel() == 2) return m_usr[0];
      return m_byp;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st = 'hF; m_ir_sr = '0; m_ir = 1; m_byp = 0; m_id = 0; m_usr = '0; m_udr = '0; m_upd = 0;
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    int sel;
    sel = m_sel();
    m_upd = 0;
    case (m_st)
      'hE: m_ir_sr = 1;
      'hA: m_ir_sr = (m_ir_sr >> 1) | (IR_W'(tdi) << (IR_W - 1));
      'hD: m_ir = m_ir_sr;
      'h6: begin
        if (sel == 1) m_id = ID;
        else if (sel == 2) m_usr = m_udr;
        else m_byp = 0;
      end
      'h2: begin
        if (sel == 1) m_id = (m_id >> 1) | (32'(tdi) << 31);
        else if (sel == 2) m_usr = (m_usr >> 1) | (DR_W'(tdi) << (DR_W - 1));
        else m_byp = tdi;
      end
      'h5: if (sel == 2) begin m_udr = m_usr; m_upd = 1; end
      default: ;
    endcase
    m_st = tms ? nx1[m_st] : nx0[m_st];
    if (m_st == 'hF) m_ir = 1;
  endtask

  task automatic tick(input bit tms, input bit tdi, output bit tdo_seen);
    @(negedge GCLK_Pad);
    chk("obs", 32'(obs), 32'(m_st));
    chk("tdo", 32'(TDO_Pad), 32'(m_tdo()));
    chk("ir_q", 32'(ir_q), 32'(m_ir));
    chk("user_dr_q", 32'(user_dr_q), 32'(m_udr));
    chk("user_upd", 32'(user_upd), 32'(m_upd));
    tdo_seen = TDO_Pad;
    TMS_Pad = tms;
    TDI_Pad = tdi;
    model_step(tms, tdi);
  endtask

  task automatic async_reset();
    @(negedge GCLK_Pad);
    #2 TRST_Pad = 1'b0;
    #1;
    chk("rst_obs", 32'(obs), 32'hF);
    chk("rst_ir", 32'(ir_q), 32'd1);
    chk("rst_udr", 32'(user_dr_q), 32'd0);
    chk("rst_upd", 32'(user_upd), 32'd0);
    chk("rst_tdo", 32'(TDO_Pad), 32'd0);
    model_reset();
    TMS_Pad = 1'b1;
    @(negedge GCLK_Pad);
    @(negedge GCLK_Pad);
    TRST_Pad = 1'b1;
  endtask

  task automatic to_rti();
    bit t;
    for (int i = 0; i < 5; i++) tick(1, 0, t);
    tick(0, 0, t);
  endtask

  task automatic load_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] tdo_bits);
    bit t;
    tick(1, 0, t); tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    for (int i = 0; i < IR_W; i++) begin
      tick(i == IR_W - 1, val[i], t);
      tdo_bits[i] = t;
    end
    tick(1, 0, t); tick(0, 0, t);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] data, output logic [63:0] tdo_bits);
    bit t;
    tdo_bits = '0;
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, data[i], t);
      tdo_bits[i] = t;
    end
    tick(1, 0, t); tick(0, 0, t);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit t;
    int cnt0;
    logic [IR_W-1:0] irt;
    logic [63:0] dt;

    model_reset();
    repeat (3) @(negedge GCLK_Pad);
    chk("por_obs", 32'(obs), 32'hF);
    chk("por_ir", 32'(ir_q), 32'd1);
    TRST_Pad = 1'b1;

    // IDCODE read straight out of reset.
    tick(0, 0, t);
    shift_dr(32, 64'h0, dt);
    chk("idcode_tdo", dt[31:0], ID);

    // Five TMS=1 edges from RTI land in TLR.
    for (int i = 0; i < 5; i++) tick(1, 0, t);
    @(negedge GCLK_Pad);
    chk("five_ones_tlr", 32'(obs), 32'hF);
    tick(0, 0, t);

    // USER register load with update pulse.
    cnt0 = upd_cnt;
    load_ir(IR_W'(2), irt);
    shift_dr(DR_W, 64'hA5, dt);
    tick(0, 0, t); tick(0, 0, t);
    chk("user_dr_a5", 32'(user_dr_q), 32'hA5);
    chk("user_upd_once", 32'(upd_cnt - cnt0), 32'd1);

    // All-ones instruction is BYPASS.
    load_ir(IR_W'(4'hF), irt);
    shift_dr(3, 64'b101, dt);
    chk("bypass_f", dt[2:0], 3'b010);

    // Unassigned instruction 6 behaves as BYPASS; IR scan shows the capture pattern.
    load_ir(IR_W'(4'b0110), irt);
    chk("ir_capture", 32'(irt), 32'b0001);
    tick(0, 0, t);
    chk("ir_is_6", 32'(ir_q), 32'd6);
    shift_dr(3, 64'b101, dt);
    chk("bypass_6", dt[2:0], 3'b010);

    // Reset in the middle of a USER shift: no update, back to TLR.
    load_ir(IR_W'(2), irt);
    cnt0 = upd_cnt;
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    tick(0, 1, t); tick(0, 0, t); tick(0, 1, t);
    async_reset();
    tick(1, 0, t); tick(1, 0, t);
    chk("midshift_ir", 32'(ir_q), 32'd1);
    chk("midshift_no_upd", 32'(upd_cnt - cnt0), 32'd0);

    // Random instruction/data scans and free TMS walks.
    for (int it = 0; it < 40; it++) begin
      to_rti();
      load_ir(IR_W'($urandom_range(0, 15)), irt);
      chk("rand_ir_capture", 32'(irt), 32'b0001);
      dt = {$urandom, $urandom};
      shift_dr($urandom_range(1, 40), dt, dt);
      for (int k = 0; k < 25; k++) tick(($urandom % 3) == 0, $urandom % 2, t);
      if (($urandom % 8) == 0) async_reset();
    end
    tick(1, 0, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
